// File: rtl/bram_window_reader_if.sv
// Bundle between the window reader and its neighbours: BRAM read port,
// pixel-group stream and pass control/status.
interface bram_window_reader_if #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_W    = 16
);
  logic                   i_start;
  logic                   i_abort;
  logic                   i_ready;
  logic [RAM_WIDTH-1:0]   i_mem_data;
  logic                   o_mem_en;
  logic [ADDR_W-1:0]      o_mem_addr;
  logic [3*RAM_WIDTH-1:0] o_pixels;
  logic                   o_valid;
  logic                   o_row_first;
  logic                   o_busy;
  logic                   o_done;

  modport master (
    input  i_start, i_abort, i_ready, i_mem_data,
    output o_mem_en, o_mem_addr, o_pixels, o_valid, o_row_first, o_busy, o_done
  );

  modport slave (
    output i_start, i_abort, i_ready, i_mem_data,
    input  o_mem_en, o_mem_addr, o_pixels, o_valid, o_row_first, o_busy, o_done
  );
endinterface

// File: rtl/bram_window_reader.sv
// Walks a loaded frame in 3-pixel horizontal groups, one column stripe at a
// time, and streams each group downstream while owning the BRAM read port.
module bram_window_reader #(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_DEPTH    = 65536,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  bram_window_reader_if.master bus
);
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

  localparam int          ADDR_W     = clogb2(RAM_DEPTH - 1);
  localparam longint      FRAME_SIZE = longint'(IMAGE_WIDTH) * longint'(IMAGE_HEIGHT);
  localparam int unsigned LAST_COL   = IMAGE_WIDTH - 3;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMAGE_WIDTH);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            col;
  logic [ADDR_W-1:0]            row_addr;
  logic [1:0]                   k;
  logic [2:0][RAM_WIDTH-1:0]    cap;
  logic                         done;
  logic                         last_row;

  // Wide compare so large frames cannot wrap the end-of-stripe test.
  assign last_row = (64'(row_addr) + 64'(IMAGE_WIDTH)) >= 64'(FRAME_SIZE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      col      <= '0;
      row_addr <= '0;
      k        <= '0;
      cap      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.i_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_start) begin
              state    <= ISSUE;
              col      <= '0;
              row_addr <= '0;
              k        <= '0;
            end
          end
          ISSUE: begin
            // Data returned this cycle belongs to the address issued last cycle.
            if (k != 2'd0) cap[k - 2'd1] <= bus.i_mem_data;
            if (k == 2'd2) state <= CAPTURE;
            else           k     <= k + 2'd1;
          end
          CAPTURE: begin
            cap[2] <= bus.i_mem_data;
            state  <= OUT;
          end
          OUT: begin
            if (bus.i_ready) begin
              if (last_row && (32'(col) == LAST_COL)) begin
                state <= IDLE;
                done  <= 1'b1;
              end else if (last_row) begin
                col      <= col + ONE;
                row_addr <= col + ONE;
                k        <= '0;
                state    <= ISSUE;
              end else begin
                row_addr <= row_addr + ROW_STEP;
                k        <= '0;
                state    <= ISSUE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_mem_en    = (state == ISSUE);
  assign bus.o_mem_addr  = row_addr + ADDR_W'(k);
  assign bus.o_pixels    = cap;
  assign bus.o_valid     = (state == OUT);
  assign bus.o_row_first = (state == OUT) && (row_addr == col);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_done      = done;
endmodule

// File: tb/tb_bram_window_reader.sv
// Directed bench for bram_window_reader: default 10x10 frame plus a 3x1 frame,
// each backed by a 1-cycle-latency BRAM model holding mem[a]=a.
`timescale 1ns/1ps
module tb_bram_window_reader;
  localparam int W      = 10;
  localparam int H      = 10;
  localparam int GROUPS = (W - 2) * H;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   numChecks = 0;
  int   numFails  = 0;

  bram_window_reader_if #(.RAM_WIDTH(8), .ADDR_W(16)) bus ();
  bram_window_reader_if #(.RAM_WIDTH(8), .ADDR_W(16)) busS ();

  bram_window_reader #(.RAM_WIDTH(8), .RAM_DEPTH(65536), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  bram_window_reader #(.RAM_WIDTH(8), .RAM_DEPTH(65536), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(1)) dutSmall (
    .clk(clk), .reset(reset), .bus(busS)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.o_mem_en)  bus.i_mem_data  <= bus.o_mem_addr[7:0];
  always @(posedge clk) if (busS.o_mem_en) busS.i_mem_data <= busS.o_mem_addr[7:0];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit abort, input bit ready);
    bus.i_start = start;
    bus.i_abort = abort;
    bus.i_ready = ready;
  endtask

  // Group g in stripe order: column g/H, row g%H, leftmost pixel at row*W+col.
  function automatic logic [23:0] expPixels(input int g);
    int b;
    b = (g % H) * W + (g / H);
    return {8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  // mode 0: ready high, 1: 7-cycle stall at first group, 2: random ready, 3: start pulses mid-pass
  task automatic runPass(input int mode, input string name);
    int          cyc;
    int          g;
    int          lastHs;
    int          finalHs;
    int          doneCnt;
    bit          rdy;
    bit          prevValid;
    bit          prevReady;
    logic [23:0] prevPix;
    cyc = 0; g = 0; lastHs = 0; finalHs = -1; doneCnt = 0;
    prevValid = 0; prevReady = 0; prevPix = '0;
    @(negedge clk);
    applyStimulus(1, 0, 1);
    checkOutput({name, "_busy_c0"}, 32'(bus.o_busy), 0);
    while (cyc < 3000 && (finalHs < 0 || cyc < finalHs + 3)) begin
      @(negedge clk);
      cyc++;
      rdy = 1;
      if (mode == 1 && cyc >= 5 && cyc <= 11) rdy = 0;
      if (mode == 2) rdy = ($urandom_range(0, 1) == 1);
      applyStimulus(mode == 3 && (cyc == 3 || cyc == 7 || cyc == 55 || cyc == 200), 0, rdy);
      if (prevValid && !prevReady) begin
        checkOutput({name, "_hold_valid"}, 32'(bus.o_valid), 1);
        checkOutput({name, "_hold_pixels"}, 32'(bus.o_pixels), 32'(prevPix));
        checkOutput({name, "_stall_mem_en"}, 32'(bus.o_mem_en), 0);
      end
      checkOutput({name, "_busy"}, 32'(bus.o_busy), (finalHs < 0) ? 1 : 0);
      checkOutput({name, "_done"}, 32'(bus.o_done), (finalHs >= 0 && cyc == finalHs + 1) ? 1 : 0);
      if (bus.o_done) doneCnt++;
      if (mode == 0 && cyc == 5)   checkOutput({name, "_c5_pixels"}, 32'(bus.o_pixels), 32'h020100);
      if (mode == 0 && cyc == 10)  checkOutput({name, "_c10_pixels"}, 32'(bus.o_pixels), 32'h0C0B0A);
      if (mode == 0 && cyc == 55)  checkOutput({name, "_c55_pixels"}, 32'(bus.o_pixels), 32'h030201);
      if (mode == 0 && cyc == 400) checkOutput({name, "_c400_pixels"}, 32'(bus.o_pixels), 32'h636261);
      if (bus.o_valid && rdy) begin
        if (g < GROUPS) begin
          checkOutput({name, "_pixels"}, 32'(bus.o_pixels), 32'(expPixels(g)));
          checkOutput({name, "_row_first"}, 32'(bus.o_row_first), (g % H == 0) ? 1 : 0);
        end
        if (mode != 2)
          checkOutput({name, "_hs_cycle"}, cyc, (g == 0) ? ((mode == 1) ? 12 : 5) : lastHs + 5);
        lastHs = cyc;
        g++;
        if (g == GROUPS) finalHs = cyc;
      end
      prevValid = bus.o_valid;
      prevReady = rdy;
      prevPix   = bus.o_pixels;
    end
    applyStimulus(0, 0, 1);
    checkOutput({name, "_group_count"}, g, GROUPS);
    checkOutput({name, "_done_count"}, doneCnt, 1);
    if (mode == 0) checkOutput({name, "_final_cycle"}, finalHs, 400);
  endtask

  task automatic runAbort();
    @(negedge clk);
    applyStimulus(1, 0, 1);
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1);
    end
    @(negedge clk);
    checkOutput("abort_g12_valid", 32'(bus.o_valid), 1);
    checkOutput("abort_g12_pixels", 32'(bus.o_pixels), 32'h0D0C0B);
    applyStimulus(0, 1, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1);
    checkOutput("abort_busy", 32'(bus.o_busy), 0);
    checkOutput("abort_valid", 32'(bus.o_valid), 0);
    checkOutput("abort_mem_en", 32'(bus.o_mem_en), 0);
    checkOutput("abort_done", 32'(bus.o_done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(bus.o_done), 0);
      checkOutput("abort_stays_idle", 32'(bus.o_busy), 0);
    end
    applyStimulus(1, 1, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1);
    checkOutput("start_abort_idle", 32'(bus.o_busy), 0);
    applyStimulus(1, 0, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1);
    end
    checkOutput("restart_valid", 32'(bus.o_valid), 1);
    checkOutput("restart_pixels", 32'(bus.o_pixels), 32'h020100);
    checkOutput("restart_row_first", 32'(bus.o_row_first), 1);
    applyStimulus(0, 1, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_valid"}, 32'(bus.o_valid), 0);
    checkOutput({name, "_pixels"}, 32'(bus.o_pixels), 0);
    checkOutput({name, "_mem_en"}, 32'(bus.o_mem_en), 0);
    checkOutput({name, "_mem_addr"}, 32'(bus.o_mem_addr), 0);
    checkOutput({name, "_row_first"}, 32'(bus.o_row_first), 0);
    checkOutput({name, "_busy"}, 32'(bus.o_busy), 0);
    checkOutput({name, "_done"}, 32'(bus.o_done), 0);
  endtask

  task automatic runResetMidPass();
    @(negedge clk);
    applyStimulus(1, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1);
    @(negedge clk);
    checkOutput("issue_mem_en", 32'(bus.o_mem_en), 1);
    checkOutput("issue_mem_addr", 32'(bus.o_mem_addr), 1);
    #1 reset = 1'b0;
    #1 checkResetValues("async_rst");
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("post_rst_busy", 32'(bus.o_busy), 0);
      checkOutput("post_rst_valid", 32'(bus.o_valid), 0);
    end
    applyStimulus(1, 0, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      applyStimulus(0, 0, 1);
    end
    checkOutput("post_rst_pixels", 32'(bus.o_pixels), 32'h020100);
    applyStimulus(0, 1, 1);
    @(negedge clk);
    applyStimulus(0, 0, 1);
  endtask

  task automatic runSmall();
    int cnt;
    int doneCyc;
    cnt = 0; doneCyc = -1;
    @(negedge clk);
    busS.i_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      busS.i_start = 1'b0;
      if (busS.o_valid) begin
        checkOutput("small_pixels", 32'(busS.o_pixels), 32'h020100);
        checkOutput("small_row_first", 32'(busS.o_row_first), 1);
        checkOutput("small_hs_cycle", c, 5);
        cnt++;
      end
      if (busS.o_done) doneCyc = c;
    end
    checkOutput("small_group_count", cnt, 1);
    checkOutput("small_done_cycle", doneCyc, 6);
    checkOutput("small_busy_end", 32'(busS.o_busy), 0);
  endtask

  initial begin
    applyStimulus(0, 0, 1);
    busS.i_start = 1'b0;
    busS.i_abort = 1'b0;
    busS.i_ready = 1'b1;
    #1 checkResetValues("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    runPass(0, "ready_high");
    runPass(1, "stall");
    runPass(2, "random_ready");
    runPass(3, "start_ignored");
    runAbort();
    runResetMidPass();
    runSmall();
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
